multicycle_control_unit: RTL and testbench

Multicycle successor to the single-cycle control decode. It is an FSM that sequences each MIPS instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects using the shared regdst_t / memtoreg_t / extop_t / opfunc_t types.
- Handshakes with the memory/cache via ihit/dhit, with a parametrised hit timeout.
- Adds a retired-instruction counter, a sticky illegal-opcode flag and a memory-error halt.

---
 rtl/control_unit_types_pkg.sv | 44 ++++
 rtl/multicycle_decode.sv | 76 +++++++
 rtl/multicycle_control_unit.sv | 214 +++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_types_pkg.sv
// Shared control-decode types for the single- and multicycle MIPS control units.
// Opcode/funct constants and small decode helpers live here as well.
package control_unit_types_pkg;

   typedef enum logic [1:0] {RD = 2'd0, RT = 2'd1, R31 = 2'd2} regdst_t;
   typedef enum logic [1:0] {ALUO = 2'd0, DLOAD = 2'd1, NPC = 2'd2} memtoreg_t;
   typedef enum logic [1:0] {ZEROEXT = 2'd0, SIGNEXT = 2'd1, SHAMEXT = 2'd2, LUIEXT = 2'd3} extop_t;
   typedef enum logic [1:0] {PC4 = 2'd0, PCBR = 2'd1, PCJ = 2'd2, PCJR = 2'd3} pcsrc_t;

   typedef enum logic [3:0] {
      OTHERR, OSL, OJR, OJ, OJAL, OBEQ, OBNE, OLW, OSW, OTHERI, OLUI, OUNK
   } opfunc_t;

   typedef enum logic [3:0] {
      RESET, FETCH, DECODE, EXEC, MEMRD, MEMWR, WBACK, HALTED, MERROR
   } mcstate_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_XORI  = 6'h0e;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;
   localparam logic [5:0] FN_JR  = 6'h08;

   // Logical immediates take a zero-extended operand; the rest of OTHERI is signed.
   function automatic logic imm_is_logical(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
   endfunction

endpackage

// File: rtl/multicycle_decode.sv
// Combinational instruction decode: instr -> opfunc class plus extender, ALU-B and
// destination-register selects. Shared with the single-cycle control unit.
module multicycle_decode
   import control_unit_types_pkg::*;
(
   input  logic [31:0] instr,
   output opfunc_t     opfunc,
   output extop_t      extop,
   output logic        alusrc,
   output regdst_t     regdst
);

   logic [5:0] op;
   logic [5:0] funct;

   assign op    = instr[31:26];
   assign funct = instr[5:0];

   always_comb begin
      opfunc = OUNK;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_SLL, FN_SRL, FN_SRA: opfunc = OSL;
               FN_JR:                  opfunc = OJR;
               default:                opfunc = OTHERR;
            endcase
         end
         OP_J:   opfunc = OJ;
         OP_JAL: opfunc = OJAL;
         OP_BEQ: opfunc = OBEQ;
         OP_BNE: opfunc = OBNE;
         OP_LW:  opfunc = OLW;
         OP_SW:  opfunc = OSW;
         OP_LUI: opfunc = OLUI;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI: opfunc = OTHERI;
         default: opfunc = OUNK;
      endcase
   end

   always_comb begin
      extop  = ZEROEXT;
      alusrc = 1'b0;
      regdst = RD;
      case (opfunc)
         OBEQ, OBNE: extop = SIGNEXT;
         OLW: begin
            extop  = SIGNEXT;
            alusrc = 1'b1;
            regdst = RT;
         end
         OSW: begin
            extop  = SIGNEXT;
            alusrc = 1'b1;
         end
         OTHERI: begin
            extop  = imm_is_logical(op) ? ZEROEXT : SIGNEXT;
            alusrc = 1'b1;
            regdst = RT;
         end
         OLUI: begin
            extop  = LUIEXT;
            alusrc = 1'b1;
            regdst = RT;
         end
         OSL: begin
            extop  = SHAMEXT;
            alusrc = 1'b1;
         end
         OJAL:    regdst = R31;
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences each instruction through fetch, decode,
// execute, memory and writeback, with ihit/dhit handshakes and a wait timeout.
//
//   state  | meaning
//   RESET  | one idle cycle after reset release
//   FETCH  | iREN asserted, waiting for ihit; loads IR and PC+4 on hit
//   DECODE | halt/jump resolution, illegal-opcode detection
//   EXEC   | branch resolution, dispatch to memory or writeback
//   MEMRD  | dREN asserted, register write on dhit
//   MEMWR  | dWEN asserted, completes on dhit
//   WBACK  | ALU result written to rd/rt
//   HALTED | halt opcode seen; absorbing until reset
//   MERROR | ihit/dhit timeout; absorbing until reset
module multicycle_control_unit
   import control_unit_types_pkg::*;
#(
   parameter int         TIMEOUT = 255,
   parameter logic [5:0] HALT_OP = 6'h3f,
   parameter int         CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [31:0]      instr,
   input  logic             equal,
   input  logic             ihit,
   input  logic             dhit,
   output logic             iREN,
   output logic             dREN,
   output logic             dWEN,
   output logic             ir_wen,
   output logic             pc_wen,
   output pcsrc_t           pcsrc,
   output logic             reg_wen,
   output regdst_t          regdst,
   output memtoreg_t        memtoreg,
   output extop_t           extop,
   output logic             alusrc,
   output opfunc_t          opfunc,
   output logic             halt,
   output logic             illegal,
   output logic             mem_err,
   output logic [CNT_W-1:0] retired
);

   localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] RELOAD = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

   mcstate_t          state;
   logic [WAIT_W-1:0] wait_left;
   logic              waiting;
   logic              expired;
   logic              is_halt;
   opfunc_t           dec_opfunc;
   extop_t            dec_extop;
   logic              dec_alusrc;
   regdst_t           dec_regdst;

   multicycle_decode u_decode (
      .instr  (instr),
      .opfunc (dec_opfunc),
      .extop  (dec_extop),
      .alusrc (dec_alusrc),
      .regdst (dec_regdst)
   );

   assign is_halt = (instr[31:26] == HALT_OP);
   assign waiting = ((state == FETCH) && !ihit) ||
                    (((state == MEMRD) || (state == MEMWR)) && !dhit);
   // Terminal count of the down-counter; a hit in the same cycle takes priority.
   assign expired = (TIMEOUT != 0) && (wait_left == '0);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= RESET;
         wait_left <= RELOAD;
         retired   <= '0;
         illegal   <= 1'b0;
         mem_err   <= 1'b0;
      end else begin
         wait_left <= (waiting && !expired) ? wait_left - 1'b1 : RELOAD;
         case (state)
            RESET: state <= FETCH;
            FETCH: begin
               if (ihit) begin
                  state <= DECODE;
               end else if (expired) begin
                  mem_err <= 1'b1;
                  state   <= MERROR;
               end
            end
            DECODE: begin
               if (is_halt) begin
                  state   <= HALTED;
                  retired <= retired + 1'b1;
               end else begin
                  case (dec_opfunc)
                     OJ, OJAL, OJR: begin
                        state   <= FETCH;
                        retired <= retired + 1'b1;
                     end
                     OUNK: begin
                        illegal <= 1'b1;
                        state   <= FETCH;
                     end
                     default: state <= EXEC;
                  endcase
               end
            end
            EXEC: begin
               case (dec_opfunc)
                  OBEQ, OBNE: begin
                     state   <= FETCH;
                     retired <= retired + 1'b1;
                  end
                  OLW:     state <= MEMRD;
                  OSW:     state <= MEMWR;
                  default: state <= WBACK;
               endcase
            end
            MEMRD, MEMWR: begin
               if (dhit) begin
                  state   <= FETCH;
                  retired <= retired + 1'b1;
               end else if (expired) begin
                  mem_err <= 1'b1;
                  state   <= MERROR;
               end
            end
            WBACK: begin
               state   <= FETCH;
               retired <= retired + 1'b1;
            end
            HALTED, MERROR: state <= state;
            default:        state <= RESET;
         endcase
      end
   end

   // Strobes are gated by the live hit inputs so writes land on the hit cycle itself.
   always_comb begin
      iREN     = 1'b0;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      ir_wen   = 1'b0;
      pc_wen   = 1'b0;
      pcsrc    = PC4;
      reg_wen  = 1'b0;
      regdst   = RD;
      memtoreg = ALUO;
      extop    = ZEROEXT;
      alusrc   = 1'b0;
      opfunc   = OTHERR;
      halt     = 1'b0;
      if (state inside {DECODE, EXEC, MEMRD, MEMWR, WBACK}) begin
         opfunc = dec_opfunc;
         extop  = dec_extop;
         alusrc = dec_alusrc;
         regdst = dec_regdst;
      end
      case (state)
         FETCH: begin
            iREN   = 1'b1;
            ir_wen = ihit;
            pc_wen = ihit;
         end
         DECODE: begin
            if (!is_halt) begin
               case (dec_opfunc)
                  OJ: begin
                     pc_wen = 1'b1;
                     pcsrc  = PCJ;
                  end
                  OJAL: begin
                     pc_wen   = 1'b1;
                     pcsrc    = PCJ;
                     reg_wen  = 1'b1;
                     regdst   = R31;
                     memtoreg = NPC;
                  end
                  OJR: begin
                     pc_wen = 1'b1;
                     pcsrc  = PCJR;
                  end
                  default: ;
               endcase
            end
         end
         EXEC: begin
            if (dec_opfunc == OBEQ) begin
               pc_wen = equal;
               pcsrc  = PCBR;
            end else if (dec_opfunc == OBNE) begin
               pc_wen = ~equal;
               pcsrc  = PCBR;
            end
         end
         MEMRD: begin
            dREN     = 1'b1;
            memtoreg = DLOAD;
            regdst   = RT;
            reg_wen  = dhit;
         end
         MEMWR: dWEN = 1'b1;
         WBACK: begin
            reg_wen  = 1'b1;
            memtoreg = ALUO;
            regdst   = ((dec_opfunc == OTHERI) || (dec_opfunc == OLUI)) ? RT : RD;
         end
         HALTED, MERROR: halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle vector table for a full instruction
// mix, plus hand-written timeout, async-reset and counter-wrap sequences.
module tb_multicycle_control_unit;
   import control_unit_types_pkg::*;

   typedef struct packed {
      logic [4:0] str;      // {iREN, dREN, dWEN, ir_wen, pc_wen}
      logic [1:0] pcsrc;
      logic       reg_wen;
      logic [1:0] regdst;
      logic [1:0] memtoreg;
      logic [1:0] extop;
      logic       alusrc;
      logic [2:0] flg;      // {halt, illegal, mem_err}
      logic [3:0] retired;
   } obs_t;

   typedef struct {
      string       tag;
      logic [31:0] instr;
      logic        ihit;
      logic        dhit;
      logic        equal;
      obs_t        exp;
   } vec_t;

   localparam logic [31:0] I_ADD  = 32'h012A4020;
   localparam logic [31:0] I_LW   = 32'h8D090004;
   localparam logic [31:0] I_SW   = 32'hAD090004;
   localparam logic [31:0] I_BEQ  = 32'h11090003;
   localparam logic [31:0] I_BNE  = 32'h15090002;
   localparam logic [31:0] I_J    = 32'h08000000;
   localparam logic [31:0] I_JAL  = 32'h0C000010;
   localparam logic [31:0] I_JR   = 32'h03E00008;
   localparam logic [31:0] I_ORI  = 32'h340900FF;
   localparam logic [31:0] I_LUI  = 32'h3C091234;
   localparam logic [31:0] I_BAD  = 32'hF8000000;
   localparam logic [31:0] I_HALT = 32'hFC000000;

   localparam logic [4:0] S_0  = 5'b00000;
   localparam logic [4:0] S_F  = 5'b10000;
   localparam logic [4:0] S_FH = 5'b10011;
   localparam logic [4:0] S_PC = 5'b00001;
   localparam logic [4:0] S_RD = 5'b01000;
   localparam logic [4:0] S_WR = 5'b00100;
   localparam logic [2:0] F_0  = 3'b000;
   localparam logic [2:0] F_IL = 3'b010;
   localparam logic [2:0] F_HI = 3'b110;
   localparam logic [2:0] F_ME = 3'b101;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic [31:0] instr = '0;
   logic        equal = 1'b0;
   logic        ihit = 1'b0;
   logic        dhit = 1'b0;
   logic        iREN, dREN, dWEN, ir_wen, pc_wen, reg_wen, alusrc, halt, illegal, mem_err;
   pcsrc_t      pcsrc;
   regdst_t     regdst;
   memtoreg_t   memtoreg;
   extop_t      extop;
   opfunc_t     opfunc;
   logic [3:0]  retired;
   obs_t        act;

   int ncmp = 0;
   int nfail = 0;
   vec_t vecs[$];

   multicycle_control_unit #(.TIMEOUT(4), .HALT_OP(6'h3f), .CNT_W(4)) dut (
      .CLK(CLK), .nRST(nRST), .instr(instr), .equal(equal), .ihit(ihit), .dhit(dhit),
      .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .ir_wen(ir_wen), .pc_wen(pc_wen),
      .pcsrc(pcsrc), .reg_wen(reg_wen), .regdst(regdst), .memtoreg(memtoreg),
      .extop(extop), .alusrc(alusrc), .opfunc(opfunc), .halt(halt),
      .illegal(illegal), .mem_err(mem_err), .retired(retired)
   );

   always #5 CLK = ~CLK;

   assign act = {iREN, dREN, dWEN, ir_wen, pc_wen, pcsrc, reg_wen, regdst, memtoreg,
                 extop, alusrc, halt, illegal, mem_err, retired};

   function automatic obs_t ob(input logic [4:0] s, input pcsrc_t p, input logic rw,
                               input regdst_t rd, input memtoreg_t m, input extop_t e,
                               input logic a, input logic [2:0] f, input logic [3:0] r);
      obs_t o;
      o = {s, p, rw, rd, m, e, a, f, r};
      return o;
   endfunction

   function automatic void add(input string tag, input logic [31:0] i, input logic ih,
                               input logic dh, input logic eq, input obs_t e);
      vec_t v;
      v.tag = tag; v.instr = i; v.ihit = ih; v.dhit = dh; v.equal = eq; v.exp = e;
      vecs.push_back(v);
   endfunction

   task automatic check(input string tag, input obs_t exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %b want %b", tag, act, exp);
      end
   endtask

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      ncmp++;
      if (got !== want) begin
         nfail++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // Drive inputs just after a rising edge, then settle to the falling edge for sampling.
   task automatic step(input logic [31:0] i, input logic ih, input logic dh, input logic eq);
      instr = i; ihit = ih; dhit = dh; equal = eq;
      @(negedge CLK);
   endtask

   task automatic adv();
      @(posedge CLK);
      #1;
   endtask

   task automatic reset_dut();
      nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; equal = 1'b0; instr = '0;
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state with hits asserted: nothing may strobe.
      nRST = 1'b0; ihit = 1'b1; dhit = 1'b1; instr = I_JAL;
      #3;
      check("in_reset", ob(S_0, PC4, 1'b0, RD, ALUO, ZEROEXT, 1'b0, F_0, 4'd0));
      reset_dut();

      add("reset_cycle", I_ADD, 1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b0, RD, ALUO, ZEROEXT, 1'b0, F_0, 4'd0));
      for (int k = 0; k < 3; k++)
         add("fetch_wait", I_ADD, 1'b0, 1'b0, 1'b0, ob(S_F, PC4, 1'b0, RD, ALUO, ZEROEXT, 1'b0, F_0, 4'd0));
      add("fetch_hit_tc", I_ADD, 1'b1, 1'b0, 1'b0, ob(S_FH, PC4, 1'b0, RD, ALUO, ZEROEXT, 1'b0, F_0, 4'd0));
      add("add_dec",   I_ADD, 1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_0, 4'd0));
      add("add_exec",  I_ADD, 1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_0, 4'd0));
      add("add_wb",    I_ADD, 1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b1, RD,  ALUO,  ZEROEXT, 1'b0, F_0, 4'd0));
      add("lw_fetch",  I_LW,  1'b1, 1'b0, 1'b0, ob(S_FH, PC4, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_0, 4'd1));
      add("lw_dec",    I_LW,  1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b0, RT,  ALUO,  SIGNEXT, 1'b1, F_0, 4'd1));
      add("lw_exec",   I_LW,  1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b0, RT,  ALUO,  SIGNEXT, 1'b1, F_0, 4'd1));
      add("lw_wait1",  I_LW,  1'b0, 1'b0, 1'b0, ob(S_RD, PC4, 1'b0, RT,  DLOAD, SIGNEXT, 1'b1, F_0, 4'd1));
      add("lw_wait2",  I_LW,  1'b0, 1'b0, 1'b0, ob(S_RD, PC4, 1'b0, RT,  DLOAD, SIGNEXT, 1'b1, F_0, 4'd1));
      add("lw_dhit",   I_LW,  1'b0, 1'b1, 1'b0, ob(S_RD, PC4, 1'b1, RT,  DLOAD, SIGNEXT, 1'b1, F_0, 4'd1));
      add("sw_fetch",  I_SW,  1'b1, 1'b0, 1'b0, ob(S_FH, PC4, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_0, 4'd2));
      add("sw_dec",    I_SW,  1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b0, RD,  ALUO,  SIGNEXT, 1'b1, F_0, 4'd2));
      add("sw_exec",   I_SW,  1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b0, RD,  ALUO,  SIGNEXT, 1'b1, F_0, 4'd2));
      add("sw_wait",   I_SW,  1'b0, 1'b0, 1'b0, ob(S_WR, PC4, 1'b0, RD,  ALUO,  SIGNEXT, 1'b1, F_0, 4'd2));
      add("sw_dhit",   I_SW,  1'b0, 1'b1, 1'b0, ob(S_WR, PC4, 1'b0, RD,  ALUO,  SIGNEXT, 1'b1, F_0, 4'd2));
      add("beq_fetch", I_BEQ, 1'b1, 1'b0, 1'b0, ob(S_FH, PC4, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_0, 4'd3));
      add("beq_dec",   I_BEQ, 1'b0, 1'b0, 1'b1, ob(S_0,  PC4, 1'b0, RD,  ALUO,  SIGNEXT, 1'b0, F_0, 4'd3));
      add("beq_taken", I_BEQ, 1'b0, 1'b0, 1'b1, ob(S_PC, PCBR, 1'b0, RD, ALUO,  SIGNEXT, 1'b0, F_0, 4'd3));
      add("beq_fetch2",I_BEQ, 1'b1, 1'b0, 1'b0, ob(S_FH, PC4, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_0, 4'd4));
      add("beq_dec2",  I_BEQ, 1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b0, RD,  ALUO,  SIGNEXT, 1'b0, F_0, 4'd4));
      add("beq_not",   I_BEQ, 1'b0, 1'b0, 1'b0, ob(S_0,  PCBR, 1'b0, RD, ALUO,  SIGNEXT, 1'b0, F_0, 4'd4));
      add("jal_fetch", I_JAL, 1'b1, 1'b0, 1'b0, ob(S_FH, PC4, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_0, 4'd5));
      add("jal_dec",   I_JAL, 1'b0, 1'b0, 1'b0, ob(S_PC, PCJ, 1'b1, R31, NPC,   ZEROEXT, 1'b0, F_0, 4'd5));
      add("bne_fetch", I_BNE, 1'b1, 1'b0, 1'b0, ob(S_FH, PC4, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_0, 4'd6));
      add("bne_dec",   I_BNE, 1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b0, RD,  ALUO,  SIGNEXT, 1'b0, F_0, 4'd6));
      add("bne_taken", I_BNE, 1'b0, 1'b0, 1'b0, ob(S_PC, PCBR, 1'b0, RD, ALUO,  SIGNEXT, 1'b0, F_0, 4'd6));
      add("j_fetch",   I_J,   1'b1, 1'b0, 1'b0, ob(S_FH, PC4, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_0, 4'd7));
      add("j_dec",     I_J,   1'b0, 1'b0, 1'b0, ob(S_PC, PCJ, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_0, 4'd7));
      add("jr_fetch",  I_JR,  1'b1, 1'b0, 1'b0, ob(S_FH, PC4, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_0, 4'd8));
      add("jr_dec",    I_JR,  1'b0, 1'b0, 1'b0, ob(S_PC, PCJR, 1'b0, RD, ALUO,  ZEROEXT, 1'b0, F_0, 4'd8));
      add("ori_fetch", I_ORI, 1'b1, 1'b0, 1'b0, ob(S_FH, PC4, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_0, 4'd9));
      add("ori_dec",   I_ORI, 1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b0, RT,  ALUO,  ZEROEXT, 1'b1, F_0, 4'd9));
      add("ori_exec",  I_ORI, 1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b0, RT,  ALUO,  ZEROEXT, 1'b1, F_0, 4'd9));
      add("ori_wb",    I_ORI, 1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b1, RT,  ALUO,  ZEROEXT, 1'b1, F_0, 4'd9));
      add("bad_fetch", I_BAD, 1'b1, 1'b0, 1'b0, ob(S_FH, PC4, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_0, 4'd10));
      add("bad_dec",   I_BAD, 1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_0, 4'd10));
      add("lui_fetch", I_LUI, 1'b1, 1'b0, 1'b0, ob(S_FH, PC4, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_IL, 4'd10));
      add("lui_dec",   I_LUI, 1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b0, RT,  ALUO,  LUIEXT,  1'b1, F_IL, 4'd10));
      add("lui_exec",  I_LUI, 1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b0, RT,  ALUO,  LUIEXT,  1'b1, F_IL, 4'd10));
      add("lui_wb",    I_LUI, 1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b1, RT,  ALUO,  LUIEXT,  1'b1, F_IL, 4'd10));
      add("hlt_fetch", I_HALT,1'b1, 1'b0, 1'b0, ob(S_FH, PC4, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_IL, 4'd11));
      add("hlt_dec",   I_HALT,1'b0, 1'b0, 1'b0, ob(S_0,  PC4, 1'b0, RD,  ALUO,  ZEROEXT, 1'b0, F_IL, 4'd11));
      for (int k = 0; k < 3; k++)
         add("halted", I_HALT, 1'b1, 1'b1, 1'b0, ob(S_0, PC4, 1'b0, RD, ALUO, ZEROEXT, 1'b0, F_HI, 4'd12));

      for (int k = 0; k < vecs.size(); k++) begin
         step(vecs[k].instr, vecs[k].ihit, vecs[k].dhit, vecs[k].equal);
         check(vecs[k].tag, vecs[k].exp);
         adv();
      end

      // ihit never arrives: MERROR after four FETCH cycles, sticky until reset.
      reset_dut();
      step(I_ADD, 1'b0, 1'b0, 1'b0); adv();
      for (int k = 0; k < 4; k++) begin
         step(I_ADD, 1'b0, 1'b0, 1'b0);
         check("ito_wait", ob(S_F, PC4, 1'b0, RD, ALUO, ZEROEXT, 1'b0, F_0, 4'd0));
         adv();
      end
      for (int k = 0; k < 3; k++) begin
         step(I_ADD, 1'b1, 1'b1, 1'b0);
         check("ito_merror", ob(S_0, PC4, 1'b0, RD, ALUO, ZEROEXT, 1'b0, F_ME, 4'd0));
         adv();
      end
      reset_dut();
      step(I_ADD, 1'b0, 1'b0, 1'b0);
      check("ito_cleared", ob(S_0, PC4, 1'b0, RD, ALUO, ZEROEXT, 1'b0, F_0, 4'd0));
      adv();

      // dhit never arrives in MEMRD.
      reset_dut();
      step(I_LW, 1'b0, 1'b0, 1'b0); adv();
      step(I_LW, 1'b1, 1'b0, 1'b0); adv();
      step(I_LW, 1'b0, 1'b0, 1'b0);
      chk_val("lw_opfunc", 32'(opfunc), 32'(OLW));
      adv();
      step(I_LW, 1'b0, 1'b0, 1'b0); adv();
      for (int k = 0; k < 4; k++) begin
         step(I_LW, 1'b0, 1'b0, 1'b0);
         check("dto_wait", ob(S_RD, PC4, 1'b0, RT, DLOAD, SIGNEXT, 1'b1, F_0, 4'd0));
         adv();
      end
      step(I_LW, 1'b0, 1'b1, 1'b0);
      check("dto_merror", ob(S_0, PC4, 1'b0, RD, ALUO, ZEROEXT, 1'b0, F_ME, 4'd0));
      adv();

      // nRST dropped mid-cycle while in MEMWR: dWEN must fall without a clock edge.
      reset_dut();
      step(I_SW, 1'b0, 1'b0, 1'b0); adv();
      step(I_SW, 1'b1, 1'b0, 1'b0); adv();
      step(I_SW, 1'b0, 1'b0, 1'b0); adv();
      step(I_SW, 1'b0, 1'b0, 1'b0); adv();
      step(I_SW, 1'b0, 1'b0, 1'b0);
      chk_val("memwr_dwen", 32'(dWEN), 32'd1);
      #2 nRST = 1'b0;
      #1;
      chk_val("async_dwen", 32'(dWEN), 32'd0);
      check("async_all", ob(S_0, PC4, 1'b0, RD, ALUO, ZEROEXT, 1'b0, F_0, 4'd0));

      // retired wraps at 2^CNT_W = 16.
      reset_dut();
      step(I_J, 1'b0, 1'b0, 1'b0); adv();
      for (int n = 1; n <= 16; n++) begin
         step(I_J, 1'b1, 1'b0, 1'b0); adv();
         step(I_J, 1'b0, 1'b0, 1'b0); adv();
         step(I_J, 1'b0, 1'b0, 1'b0);
         chk_val($sformatf("retired_%0d", n), 32'(retired), 32'(n % 16));
         adv();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
